// File: rtl/demux2_stream_if.sv
// Stream bundle for demux2_stream: one upstream channel and two routed downstream channels.
// The slave modport is the demux's view; the master modport is the surrounding environment's view.
interface demux2_stream_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sel;
  logic              s_last;

  logic              m0_valid;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_data;
  logic              m0_last;

  logic              m1_valid;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_data;
  logic              m1_last;

  modport slave (
    input  s_valid, s_data, s_sel, s_last, m0_ready, m1_ready,
    output s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last
  );

  modport master (
    output s_valid, s_data, s_sel, s_last, m0_ready, m1_ready,
    input  s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last
  );
endinterface

// File: rtl/demux2_stream.sv
// Packet-aware 1-to-2 stream demux with one output register stage per destination.
// Optional per-output saturating beat counters are enabled by defining DEMUX2_STREAM_STATS_EN.
module demux2_stream #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  demux2_stream_if.slave bus
`ifdef DEMUX2_STREAM_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_sel;

  logic              r_m0_valid;
  logic [DATA_W-1:0] r_m0_data;
  logic              r_m0_last;
  logic              r_m1_valid;
  logic [DATA_W-1:0] r_m1_data;
  logic              r_m1_last;

  logic              w_route;
  logic              w_ready;
  logic              w_accept;
  logic              w_load0;
  logic              w_load1;

  // The first beat of a packet routes on the live select; later beats use the locked one.
  assign w_route  = (r_state == BUSY) ? r_sel : bus.s_sel;
  assign w_ready  = rst_n & (w_route ? (~r_m1_valid | bus.m1_ready)
                                     : (~r_m0_valid | bus.m0_ready));
  assign w_accept = bus.s_valid & w_ready;
  assign w_load0  = w_accept & ~w_route;
  assign w_load1  = w_accept &  w_route;

  assign bus.s_ready  = w_ready;
  assign bus.m0_valid = r_m0_valid;
  assign bus.m0_data  = r_m0_data;
  assign bus.m0_last  = r_m0_last;
  assign bus.m1_valid = r_m1_valid;
  assign bus.m1_data  = r_m1_data;
  assign bus.m1_last  = r_m1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && !bus.s_last) begin
            r_state <= BUSY;
            r_sel   <= bus.s_sel;
          end
        end
        BUSY: begin
          if (w_accept && bus.s_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A load wins over a drain, so a stage can accept every cycle while its sink is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_valid <= 1'b0;
      r_m0_data  <= '0;
      r_m0_last  <= 1'b0;
    end else if (w_load0) begin
      r_m0_valid <= 1'b1;
      r_m0_data  <= bus.s_data;
      r_m0_last  <= bus.s_last;
    end else if (r_m0_valid && bus.m0_ready) begin
      r_m0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1_valid <= 1'b0;
      r_m1_data  <= '0;
      r_m1_last  <= 1'b0;
    end else if (w_load1) begin
      r_m1_valid <= 1'b1;
      r_m1_data  <= bus.s_data;
      r_m1_last  <= bus.s_last;
    end else if (r_m1_valid && bus.m1_ready) begin
      r_m1_valid <= 1'b0;
    end
  end

`ifdef DEMUX2_STREAM_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= 16'h0000;
      r_cnt1 <= 16'h0000;
    end else begin
      if (w_load0 && (r_cnt0 != 16'hFFFF)) begin
        r_cnt0 <= r_cnt0 + 16'h0001;
      end
      if (w_load1 && (r_cnt1 != 16'hFFFF)) begin
        r_cnt1 <= r_cnt1 + 16'h0001;
      end
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Directed, table-driven bench for demux2_stream; define DEMUX2_STREAM_STATS_EN to also
// exercise the saturating beat counters.
module tb_demux2_stream;

  logic clk;
  logic rst_n;

  demux2_stream_if #(.DATA_W(8)) bus ();

`ifdef DEMUX2_STREAM_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  demux2_stream #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX2_STREAM_STATS_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic       sel;
    logic       last;
    logic [7:0] data;
    logic       m0r;
    logic       m1r;
    logic       expReady;
    logic       e0v;
    logic [7:0] e0d;
    logic       e0l;
    logic       e1v;
    logic [7:0] e1d;
    logic       e1l;
  } vec_t;

  int   numChecks = 0;
  int   numFails  = 0;
  vec_t vecs[12];

  function automatic vec_t mk(input logic sv, input logic sel, input logic last,
                              input logic [7:0] data, input logic m0r, input logic m1r,
                              input logic expReady,
                              input logic e0v, input logic [7:0] e0d, input logic e0l,
                              input logic e1v, input logic [7:0] e1d, input logic e1l);
    vec_t v;
    v.sv = sv; v.sel = sel; v.last = last; v.data = data; v.m0r = m0r; v.m1r = m1r;
    v.expReady = expReady;
    v.e0v = e0v; v.e0d = e0d; v.e0l = e0l;
    v.e1v = e1v; v.e1d = e1d; v.e1l = e1l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic sel, input logic last,
                               input logic [7:0] data, input logic m0r, input logic m1r);
    bus.s_valid  = sv;
    bus.s_sel    = sel;
    bus.s_last   = last;
    bus.s_data   = data;
    bus.m0_ready = m0r;
    bus.m1_ready = m1r;
  endtask

  task automatic checkOutput(input string tag, input logic e0v, input logic [7:0] e0d,
                             input logic e0l, input logic e1v, input logic [7:0] e1d,
                             input logic e1l);
    check({tag, " m0_valid"}, 32'(bus.m0_valid), 32'(e0v));
    check({tag, " m0_data"},  32'(bus.m0_data),  32'(e0d));
    check({tag, " m0_last"},  32'(bus.m0_last),  32'(e0l));
    check({tag, " m1_valid"}, 32'(bus.m1_valid), 32'(e1v));
    check({tag, " m1_data"},  32'(bus.m1_data),  32'(e1d));
    check({tag, " m1_last"},  32'(bus.m1_last),  32'(e1l));
  endtask

  initial begin
    // Single beat to output 1, then a 4-beat packet to output 0 with a wobbling select,
    // then output 0 stalled while output 1 keeps flowing.
    vecs[0]  = mk(0, 0, 0, 8'h00, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
    vecs[1]  = mk(1, 1, 1, 8'hA5, 1, 1, 1,  0, 8'h00, 0,  1, 8'hA5, 1);
    vecs[2]  = mk(1, 0, 0, 8'h01, 1, 1, 1,  1, 8'h01, 0,  0, 8'hA5, 1);
    vecs[3]  = mk(1, 1, 0, 8'h02, 1, 1, 1,  1, 8'h02, 0,  0, 8'hA5, 1);
    vecs[4]  = mk(1, 0, 0, 8'h03, 1, 1, 1,  1, 8'h03, 0,  0, 8'hA5, 1);
    vecs[5]  = mk(1, 1, 1, 8'h04, 1, 1, 1,  1, 8'h04, 1,  0, 8'hA5, 1);
    vecs[6]  = mk(1, 1, 1, 8'h55, 1, 1, 1,  0, 8'h04, 1,  1, 8'h55, 1);
    vecs[7]  = mk(1, 0, 1, 8'h11, 0, 1, 1,  1, 8'h11, 1,  0, 8'h55, 1);
    vecs[8]  = mk(1, 0, 1, 8'h22, 0, 1, 0,  1, 8'h11, 1,  0, 8'h55, 1);
    vecs[9]  = mk(1, 1, 1, 8'h33, 0, 1, 1,  1, 8'h11, 1,  1, 8'h33, 1);
    vecs[10] = mk(1, 0, 1, 8'h22, 1, 1, 1,  1, 8'h22, 1,  0, 8'h33, 1);
    vecs[11] = mk(0, 0, 0, 8'h00, 1, 1, 1,  0, 8'h22, 1,  0, 8'h33, 1);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    #12;
    check("reset s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("reset", 0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].sv, vecs[i].sel, vecs[i].last, vecs[i].data,
                    vecs[i].m0r, vecs[i].m1r);
      #1;
      check($sformatf("vec%0d s_ready", i), 32'(bus.s_ready), 32'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e0v, vecs[i].e0d, vecs[i].e0l,
                  vecs[i].e1v, vecs[i].e1d, vecs[i].e1l);
    end

    // Eight back-to-back beats to output 1 must appear on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(1, (i == 0) ? 1'b1 : 1'(i % 2), (i == 7), 8'(8'h80 + i), 1, 1);
      #1;
      check($sformatf("burst%0d s_ready", i), 32'(bus.s_ready), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("burst%0d m1_valid", i), 32'(bus.m1_valid), 32'd1);
      check($sformatf("burst%0d m1_data", i),  32'(bus.m1_data),  32'(8'h80 + i));
      check($sformatf("burst%0d m0_valid", i), 32'(bus.m0_valid), 32'd0);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    checkOutput("burst drain", 0, 8'h22, 1, 0, 8'h87, 1);

    // Reset in the middle of a packet locked to output 0.
    @(negedge clk);
    applyStimulus(1, 0, 0, 8'h61, 0, 1);
    @(posedge clk);
    #1;
    checkOutput("pre-reset beat1", 1, 8'h61, 0, 0, 8'h87, 1);
    @(negedge clk);
    applyStimulus(1, 1, 0, 8'h62, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("midreset", 0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 8'h77, 1, 1);
    #1;
    check("post-reset s_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("post-reset", 0, 8'h00, 0, 1, 8'h77, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);

`ifdef DEMUX2_STREAM_STATS_EN
    rst_n = 1'b0;
    #1;
    check("stats reset cnt0", 32'(cnt0), 32'd0);
    check("stats reset cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 1, 8'h5A, 1, 1);
    for (int i = 0; i < 100; i++) @(posedge clk);
    #1;
    check("stats cnt0 at 100", 32'(cnt0), 32'd100);
    for (int i = 100; i < 70000; i++) @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    check("stats cnt0 saturated", 32'(cnt0), 32'hFFFF);
    check("stats cnt1 idle", 32'(cnt1), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
